// File: rtl/pe_data_fetch_unit.sv
// Memory-side fetch/store responder between the CU/PE array and a single-port data memory.
// Optional macro PE_FETCH_LANE_CLEAR_EN zeroes unselected lanes when a fetch is accepted.
module pe_data_fetch_unit #(
  parameter int unsigned   AW      = 6,
  parameter int unsigned   DW      = 32,
  parameter logic [AW-1:0] WR_BASE = AW'(32)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ADDR_START,
  input  logic                 ADDR_RST,
  input  logic [3:0]           ADDRESS,
  input  logic [1:0]           PE_SEL,
  input  logic                 PE_SEL_2x2,
  input  logic                 PE_SEL_4,
  output logic                 FETCH_DONE,
  output logic [3:0][DW-1:0]   DATA_TO_PE,
  output logic [3:0]           LANE_VALID,
  input  logic                 WRADDR_START,
  input  logic [3:0][DW-1:0]   PE_RESULT,
  output logic                 STORE_DONE,
  output logic [AW-1:0]        MEM_ADDR,
  output logic                 MEM_RD_EN,
  input  logic [DW-1:0]        MEM_RDATA,
  output logic                 MEM_WR_EN,
  output logic [DW-1:0]        MEM_WDATA
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRd     = 3'd1;
  localparam logic [2:0] StRdTail = 3'd2;
  localparam logic [2:0] StFDone  = 3'd3;
  localparam logic [2:0] StWr     = 3'd4;
  localparam logic [2:0] StSDone  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [AW-1:0]       rbase_q, rbase_d;
  logic [AW-1:0]       wbase_q, wbase_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [3:0]          mask_q, mask_d;
  logic [3:0][DW-1:0]  snap_q, snap_d;
  logic [3:0][DW-1:0]  data_q, data_d;
  logic [3:0]          lv_q, lv_d;
  logic                rd_vld_q;
  logic [3:0]          sel_mask;
  logic                rd_en, wr_en;
  logic                fetch_acc;

  always_comb begin
    if (PE_SEL_4) begin
      sel_mask = 4'b1111;
    end else if (PE_SEL_2x2) begin
      sel_mask = PE_SEL[1] ? 4'b1100 : 4'b0011;
    end else begin
      sel_mask = 4'b0001 << PE_SEL;
    end
  end

  assign fetch_acc = (state_q == StIdle) && ADDR_START;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbase_d = rbase_q;
    wbase_d = wbase_q;
    wptr_d  = wptr_q;
    mask_d  = mask_q;
    snap_d  = snap_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ADDR_START) begin
          state_d = StRd;
          rbase_d = AW'({ADDRESS, 2'b00});
          mask_d  = sel_mask;
        end else if (WRADDR_START) begin
          state_d = StWr;
          wbase_d = wptr_q;
          snap_d  = PE_RESULT;
        end
      end
      StRd: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StRdTail;
      end
      StRdTail: begin
        // Two cycles let the last read word land in DATA_TO_PE before FETCH_DONE.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = StFDone;
          cnt_d   = '0;
        end
      end
      StFDone: begin
        if (!ADDR_START) state_d = StIdle;
      end
      StWr: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = StSDone;
          wptr_d  = wptr_q + AW'(4);
        end
      end
      StSDone: begin
        if (!WRADDR_START) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (ADDR_RST) wptr_d = WR_BASE;
  end

  // Read data arrives one cycle after the strobe and is registered once more into the lanes.
  always_comb begin
    data_d = data_q;
    lv_d   = '0;
    if (rd_vld_q) begin
      lv_d = mask_q;
      for (int l = 0; l < 4; l++) begin
        if (mask_q[l]) data_d[l] = MEM_RDATA;
      end
    end
`ifdef PE_FETCH_LANE_CLEAR_EN
    if (fetch_acc) begin
      for (int l = 0; l < 4; l++) begin
        if (!sel_mask[l]) data_d[l] = '0;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rbase_q  <= '0;
      wbase_q  <= '0;
      wptr_q   <= WR_BASE;
      mask_q   <= '0;
      snap_q   <= '0;
      data_q   <= '0;
      lv_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rbase_q  <= rbase_d;
      wbase_q  <= wbase_d;
      wptr_q   <= wptr_d;
      mask_q   <= mask_d;
      snap_q   <= snap_d;
      data_q   <= data_d;
      lv_q     <= lv_d;
      rd_vld_q <= rd_en;
    end
  end

  assign rd_en = (state_q == StRd);
  assign wr_en = (state_q == StWr);

  always_comb begin
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (rd_en) begin
      MEM_ADDR = rbase_q + AW'(cnt_q);
    end else if (wr_en) begin
      MEM_ADDR  = wbase_q + AW'(cnt_q);
      MEM_WDATA = snap_q[cnt_q];
    end
  end

  assign MEM_RD_EN  = rd_en;
  assign MEM_WR_EN  = wr_en;
  assign FETCH_DONE = (state_q == StFDone);
  assign STORE_DONE = (state_q == StSDone);
  assign DATA_TO_PE = data_q;
  assign LANE_VALID = lv_q;

endmodule

// File: tb/tb_pe_data_fetch_unit.sv
// Self-checking bench for pe_data_fetch_unit: transaction-timeline model plus directed literals.
module tb_pe_data_fetch_unit;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ADDR_START = 1'b0;
  logic             ADDR_RST = 1'b0;
  logic [3:0]       ADDRESS = '0;
  logic [1:0]       PE_SEL = '0;
  logic             PE_SEL_2x2 = 1'b0;
  logic             PE_SEL_4 = 1'b0;
  logic             FETCH_DONE;
  logic [3:0][31:0] DATA_TO_PE;
  logic [3:0]       LANE_VALID;
  logic             WRADDR_START = 1'b0;
  logic [3:0][31:0] PE_RESULT = '0;
  logic             STORE_DONE;
  logic [5:0]       MEM_ADDR;
  logic             MEM_RD_EN;
  logic [31:0]      MEM_RDATA = '0;
  logic             MEM_WR_EN;
  logic [31:0]      MEM_WDATA;

  pe_data_fetch_unit dut (
    .CLK(CLK), .RST(RST), .ADDR_START(ADDR_START), .ADDR_RST(ADDR_RST), .ADDRESS(ADDRESS),
    .PE_SEL(PE_SEL), .PE_SEL_2x2(PE_SEL_2x2), .PE_SEL_4(PE_SEL_4), .FETCH_DONE(FETCH_DONE),
    .DATA_TO_PE(DATA_TO_PE), .LANE_VALID(LANE_VALID), .WRADDR_START(WRADDR_START),
    .PE_RESULT(PE_RESULT), .STORE_DONE(STORE_DONE), .MEM_ADDR(MEM_ADDR),
    .MEM_RD_EN(MEM_RD_EN), .MEM_RDATA(MEM_RDATA), .MEM_WR_EN(MEM_WR_EN),
    .MEM_WDATA(MEM_WDATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Bench memory: reloaded on reset, one-cycle read latency.
  logic [31:0] mem [64];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
      mem[8]  <= 32'h11;
      mem[9]  <= 32'h22;
      mem[10] <= 32'h33;
      mem[11] <= 32'h44;
    end else begin
      if (MEM_RD_EN) MEM_RDATA <= mem[MEM_ADDR];
      if (MEM_WR_EN) mem[MEM_ADDR] <= MEM_WDATA;
    end
  end

  // Model: each accepted request is a timeline relative to its acceptance cycle.
  int          m_kind = 0;  // 0 idle, 1 fetch, 2 store
  int          m_acc = 0;
  logic [5:0]  m_wptr = 6'd32;
  logic [5:0]  m_base = '0;
  logic [5:0]  m_wbase = '0;
  logic [3:0]  m_mask = '0;
  logic [31:0] m_lane [4] = '{default: '0};
  logic [31:0] m_snap [4] = '{default: '0};

  always @(negedge CLK) begin
    int rel;
    int old_kind;
    logic e_rd, e_wr, e_fd, e_sd;
    logic [3:0] e_lv;
    logic [5:0] e_addr;
    logic [31:0] e_wd;
    rel = cyc - m_acc;
    e_rd = 0; e_wr = 0; e_fd = 0; e_sd = 0; e_lv = '0; e_addr = '0; e_wd = '0;
    if (m_kind == 1) begin
`ifdef PE_FETCH_LANE_CLEAR_EN
      if (rel == 1) for (int l = 0; l < 4; l++) if (!m_mask[l]) m_lane[l] = '0;
`endif
      if (rel >= 1 && rel <= 4) begin
        e_rd = 1;
        e_addr = m_base + 6'(rel - 1);
      end
      if (rel >= 3 && rel <= 6) begin
        e_lv = m_mask;
        for (int l = 0; l < 4; l++) if (m_mask[l]) m_lane[l] = mem[m_base + 6'(rel - 3)];
      end
      e_fd = (rel >= 7);
    end else if (m_kind == 2) begin
      if (rel >= 1 && rel <= 4) begin
        e_wr = 1;
        e_addr = m_wbase + 6'(rel - 1);
        e_wd = m_snap[rel - 1];
      end
      e_sd = (rel >= 5);
    end
    if (chk_en) begin
      chk("mem_rd_en", MEM_RD_EN, e_rd);
      chk("mem_wr_en", MEM_WR_EN, e_wr);
      chk("mem_addr", MEM_ADDR, e_addr);
      if (e_wr) chk("mem_wdata", MEM_WDATA, e_wd);
      chk("fetch_done", FETCH_DONE, e_fd);
      chk("store_done", STORE_DONE, e_sd);
      chk("lane_valid", LANE_VALID, e_lv);
      for (int l = 0; l < 4; l++) chk($sformatf("data_to_pe%0d", l), DATA_TO_PE[l], m_lane[l]);
    end
    old_kind = m_kind;
    if (RST) begin
      m_kind = 0;
      m_wptr = 6'd32;
      for (int l = 0; l < 4; l++) m_lane[l] = '0;
    end else begin
      if (old_kind == 1) begin
        if (rel >= 7 && !ADDR_START) m_kind = 0;
      end else if (old_kind == 2) begin
        if (rel >= 5 && !WRADDR_START) m_kind = 0;
      end else if (ADDR_START) begin
        m_kind = 1;
        m_acc = cyc;
        m_base = {ADDRESS, 2'b00};
        if (PE_SEL_4) m_mask = 4'b1111;
        else if (PE_SEL_2x2) m_mask = PE_SEL[1] ? 4'b1100 : 4'b0011;
        else m_mask = 4'(1 << PE_SEL);
      end else if (WRADDR_START) begin
        m_kind = 2;
        m_acc = cyc;
        m_wbase = m_wptr;
        for (int k = 0; k < 4; k++) m_snap[k] = PE_RESULT[k];
      end
      if (old_kind == 2 && rel == 4) m_wptr = m_wptr + 6'd4;
      if (ADDR_RST) m_wptr = 6'd32;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [3:0] a, input logic [1:0] sel, input logic s2,
                       input logic s4);
    ADDRESS = a; PE_SEL = sel; PE_SEL_2x2 = s2; PE_SEL_4 = s4; ADDR_START = 1'b1;
    for (int i = 0; i < 20 && !FETCH_DONE; i++) tick();
    chk("fetch_done_seen", FETCH_DONE, 1'b1);
    ADDR_START = 1'b0;
    tick();
    chk("fetch_done_drop", FETCH_DONE, 1'b0);
    PE_SEL_2x2 = 1'b0; PE_SEL_4 = 1'b0;
  endtask

  task automatic fetch_single_literal();
    logic [31:0] w [4];
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    ADDRESS = 4'd2; PE_SEL = 2'd1; PE_SEL_2x2 = 0; PE_SEL_4 = 0; ADDR_START = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 4) chk("s1_addr", MEM_ADDR, 32'(8 + k - 1));
      if (k >= 3 && k <= 6) begin
        chk("s1_lane_valid", LANE_VALID, 4'b0010);
        chk("s1_lane1", DATA_TO_PE[1], w[k - 3]);
      end
      if (k == 7) chk("s1_done", FETCH_DONE, 1'b1);
    end
    ADDR_START = 1'b0;
    tick();
    chk("s1_done_drop", FETCH_DONE, 1'b0);
  endtask

  task automatic store(input int seed, output logic [5:0] first);
    logic [3:0][31:0] v;
    for (int k = 0; k < 4; k++) v[k] = 32'hC000_0000 | (seed << 8) | k;
    PE_RESULT = v; WRADDR_START = 1'b1;
    tick();
    first = MEM_ADDR;
    chk("store_wr_en", MEM_WR_EN, 1'b1);
    tick();
    PE_RESULT = ~v;  // must not reach memory
    for (int i = 0; i < 20 && !STORE_DONE; i++) tick();
    chk("store_done_seen", STORE_DONE, 1'b1);
    WRADDR_START = 1'b0;
    tick();
    chk("store_done_drop", STORE_DONE, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] a;
    bit wr_seen;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_lane_valid", LANE_VALID, 4'b0);
    chk("rst_data0", DATA_TO_PE[0], 32'h0);
    RST = 1'b0;
    tick();

    fetch_single_literal();

    fetch(4'd0, 2'd0, 1'b1, 1'b1);
    for (int l = 0; l < 4; l++) chk("bcast_lane", DATA_TO_PE[l], 32'hA000_0003);
    fetch(4'd1, 2'd3, 1'b0, 1'b0);
    chk("sel3_lane3", DATA_TO_PE[3], 32'hA000_0007);
`ifdef PE_FETCH_LANE_CLEAR_EN
    chk("sel3_lane0", DATA_TO_PE[0], 32'h0);
`else
    chk("sel3_lane0", DATA_TO_PE[0], 32'hA000_0003);
`endif

    store(1, a); chk("store1_addr", a, 6'd32);
    chk("store1_mem32", mem[32], 32'hC000_0100);
    chk("store1_mem35", mem[35], 32'hC000_0103);
    store(2, a); chk("store2_addr", a, 6'd36);
    store(3, a); chk("store3_addr", a, 6'd40);
    for (int s = 4; s < 8; s++) store(s, a);
    store(8, a); chk("wrap_store_addr", a, 6'd60);
    store(9, a); chk("after_wrap_addr", a, 6'd0);

    // Simultaneous requests: fetch first, store once the fetch handshake clears.
    ADDRESS = 4'd3; PE_SEL = 2'd0; PE_RESULT = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    ADDR_START = 1'b1; WRADDR_START = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 20 && !FETCH_DONE; i++) begin
      tick();
      if (MEM_WR_EN) wr_seen = 1;
    end
    chk("sim_fetch_done", FETCH_DONE, 1'b1);
    chk("sim_no_wr_in_fetch", 32'(wr_seen), 32'h0);
    ADDR_START = 1'b0;
    tick();
    tick();
    chk("sim_store_wr", MEM_WR_EN, 1'b1);
    chk("sim_store_addr", MEM_ADDR, 6'd4);
    for (int i = 0; i < 20 && !STORE_DONE; i++) tick();
    chk("sim_store_done", STORE_DONE, 1'b1);
    WRADDR_START = 1'b0;
    tick();

    // ADDR_RST in the last WR cycle: burst finishes at 8..11, next store restarts at 32.
    PE_RESULT = {32'hE3, 32'hE2, 32'hE1, 32'hE0}; WRADDR_START = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    ADDR_RST = 1'b1;
    chk("arst_last_addr", MEM_ADDR, 6'd11);
    tick();
    ADDR_RST = 1'b0;
    chk("arst_store_done", STORE_DONE, 1'b1);
    WRADDR_START = 1'b0;
    tick();
    store(10, a); chk("arst_next_addr", a, 6'd32);

    // RST in fetch cycle 3 aborts the burst.
    ADDRESS = 4'd2; PE_SEL = 2'd1; ADDR_START = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    RST = 1'b1; ADDR_START = 1'b0;
    tick();
    chk("rst_abort_rd_en", MEM_RD_EN, 1'b0);
    chk("rst_abort_lv", LANE_VALID, 4'b0);
    chk("rst_abort_lane1", DATA_TO_PE[1], 32'h0);
    RST = 1'b0;
    tick();
    fetch_single_literal();

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
